// File: rtl/parking_request_queue.sv
// parking_request_queue
//   Front-end request buffer for the parking lot controller. It samples the
//   raw user inputs each cycle and validates every request (the plate must be
//   non-zero BCD, and exactly one direction strobe must be set). Accepted
//   requests go into a DEPTH-entry FIFO. The head entry is offered to the
//   controller over a valid/ready handshake.
//
//   Optional build macro: PARKING_QUEUE_DEDUP_EN. When it is defined, a request
//   whose plate and direction match an occupied entry is rejected as a
//   duplicate. The duplicate check takes priority over the full check.
//
// Ports
//   clock, reset          : rising-edge clock; synchronous active-high reset
//   license_plate         : raw plate, PLATE_W/4 BCD digits, MSB digit first
//   in_mode / out_mode    : one-cycle entry / exit request strobes
//   req_ready             : controller accepts the head entry this cycle
//   req_valid             : head entry available (queue not empty)
//   req_plate / req_out   : head plate and direction (0 = in, 1 = out);
//                           both are 0 while the queue is empty
//   count / full / empty  : occupancy
//   reject                : one-cycle pulse, invalid or duplicate request dropped
//   overflow              : one-cycle pulse, valid request dropped on full queue
//   drop_cnt              : saturating count of overflow events
module parking_request_queue #(
  parameter int DEPTH   = 4,
  parameter int PLATE_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PLATE_W-1:0]       license_plate,
  input  logic                     in_mode,
  input  logic                     out_mode,
  input  logic                     req_ready,
  output logic                     req_valid,
  output logic [PLATE_W-1:0]       req_plate,
  output logic                     req_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     reject,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NIB   = PLATE_W / 4;

  logic [PLATE_W-1:0] plate_q [DEPTH];
  logic               dir_q   [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             reject_q, reject_d, overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic present, plate_bad, invalid, dup, pop, push, full_w, empty_w;

  assign present = in_mode | out_mode;
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign pop     = !empty_w && req_ready;

  always_comb begin
    plate_bad = (license_plate == '0);
    for (int unsigned i = 0; i < NIB; i++) begin
      if (license_plate[4*i +: 4] > 4'd9) plate_bad = 1'b1;
    end
  end

  assign invalid = (in_mode & out_mode) | plate_bad;

`ifdef PARKING_QUEUE_DEDUP_EN
  logic [PTR_W-1:0] dup_idx;

  // Walk the occupied entries from the head. The head still counts when it
  // is popping in this same cycle.
  always_comb begin
    dup     = 1'b0;
    dup_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      dup_idx = rptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (plate_q[dup_idx] == license_plate) &&
          (dir_q[dup_idx] == out_mode)) begin
        dup = 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    reject_d   = 1'b0;
    overflow_d = 1'b0;
    push       = 1'b0;
    drop_d     = drop_q;
    if (present) begin
      if (invalid || dup) begin
        reject_d = 1'b1;
      end else if (!full_w || pop) begin
        push = 1'b1;
      end else begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      reject_q   <= reject_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset. Stale data is never visible because the head
  // outputs are forced to zero while the queue is empty.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      plate_q[wptr_q] <= license_plate;
      dir_q[wptr_q]   <= out_mode;
    end
  end

  assign req_valid = !empty_w;
  assign req_plate = empty_w ? '0 : plate_q[rptr_q];
  assign req_out   = empty_w ? 1'b0 : dir_q[rptr_q];
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign reject    = reject_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_parking_request_queue.sv
module tb_parking_request_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] plate;
    logic        dir;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] license_plate = '0;
  logic        in_mode = 1'b0, out_mode = 1'b0, req_ready = 1'b0;
  logic        req_valid, req_out, full, empty, reject, overflow;
  logic [15:0] req_plate;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t mq[$];     // queue contents as the specification rules dictate
  ent_t exp_q[$];  // scoreboard: entries the DUT must present, in order
  int   m_drop = 0;
  bit   m_rej = 0, m_ovf = 0;

  always #5 clk = ~clk;

  parking_request_queue #(.DEPTH(DEPTH), .PLATE_W(16)) dut (
    .clock(clk), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .req_ready(req_ready),
    .req_valid(req_valid), .req_plate(req_plate), .req_out(req_out),
    .count(count), .full(full), .empty(empty), .reject(reject),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit plate_invalid(input logic [15:0] p);
    if (p == 0) return 1;
    for (int k = 0; k < 4; k++) if (((p >> (4*k)) % 16) > 9) return 1;
    return 0;
  endfunction

  // Monitor: while the DUT presents a head entry, it must be the oldest
  // expected entry. A handshake retires that entry.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (req_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_valid", 1, 0);
        end else begin
          chk("mon_plate", req_plate, exp_q[0].plate);
          chk("mon_dir", req_out, exp_q[0].dir);
          if (req_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("mon_idle_plate", {req_plate, req_out}, 0);
      end
    end
  end

  task automatic cycle(input logic [15:0] p, input bit i, input bit o,
                       input bit rdy, input bit rst);
    bit   pop, acc, dupl;
    ent_t e;
    @(negedge clk);
    license_plate = p; in_mode = i; out_mode = o; req_ready = rdy; reset = rst;
    e.plate = p; e.dir = o;
    pop = rdy && (mq.size() > 0);
    acc = 0;
    if (rst) begin
      mq.delete(); m_rej = 0; m_ovf = 0; m_drop = 0;
    end else begin
      m_rej = 0; m_ovf = 0; dupl = 0;
`ifdef PARKING_QUEUE_DEDUP_EN
      foreach (mq[k]) if (mq[k].plate == p && mq[k].dir == o) dupl = 1;
`endif
      if (i || o) begin
        if ((i && o) || plate_invalid(p) || dupl) m_rej = 1;
        else if (mq.size() < DEPTH || pop) acc = 1;
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("req_valid", req_valid, mq.size() != 0);
    chk("reject", reject, m_rej);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int k = 0; k < n; k++) cycle(16'h0, 0, 0, rdy, 0);
  endtask

  logic [15:0] pool [8];

  initial begin
    pool[0] = 16'h9423; pool[1] = 16'h8754; pool[2] = 16'h1111; pool[3] = 16'h2222;
    pool[4] = 16'h0001; pool[5] = 16'h9999; pool[6] = 16'h5050; pool[7] = 16'h1234;

    cycle(16'h0, 0, 0, 0, 1);
    cycle(16'h0, 0, 0, 0, 1);

    // Single entry, head must hold while not ready
    cycle(16'h9423, 1, 0, 0, 0);
    chk("t1_plate", req_plate, 16'h9423);
    chk("t1_dir", req_out, 0);
    idle(0, 3);
    chk("t1_hold", req_plate, 16'h9423);
    idle(1, 2);

    // Ordered drain
    cycle(16'h9423, 1, 0, 0, 0);
    cycle(16'h8754, 1, 0, 0, 0);
    cycle(16'h8754, 0, 1, 0, 0);
    chk("t2_count3", count, 3);
    idle(1, 4);
    chk("t2_empty", empty, 1);

    // Full, overflow, then push with a simultaneous pop
    cycle(16'h1111, 1, 0, 0, 0);
    cycle(16'h2222, 1, 0, 0, 0);
    cycle(16'h3333, 1, 0, 0, 0);
    cycle(16'h4444, 1, 0, 0, 0);
    cycle(16'h1234, 1, 0, 0, 0);
    chk("t3_overflow", overflow, 1);
    chk("t3_drop", drop_cnt, 1);
    cycle(16'h1234, 1, 0, 1, 0);
    chk("t3_count", count, 4);
    chk("t3_no_ovf", overflow, 0);
    idle(1, 5);

    // Invalid requests
    cycle(16'h12A4, 1, 0, 0, 0);
    chk("t4_rej_nonbcd", reject, 1);
    cycle(16'h0000, 0, 1, 0, 0);
    chk("t4_rej_zero", reject, 1);
    cycle(16'h5555, 1, 1, 0, 0);
    chk("t4_rej_both", reject, 1);
    chk("t4_count", count, 0);

    // Reset mid-operation while pushing
    cycle(16'h2222, 1, 0, 0, 0);
    cycle(16'h3333, 0, 1, 0, 0);
    cycle(16'h1111, 1, 0, 0, 1);
    chk("t5_count", count, 0);
    chk("t5_drop", drop_cnt, 0);
    idle(0, 1);

    // Duplicate handling
    cycle(16'h8754, 1, 0, 0, 0);
    cycle(16'h8754, 1, 0, 0, 0);
`ifdef PARKING_QUEUE_DEDUP_EN
    chk("t6_count", count, 1);
`else
    chk("t6_count", count, 2);
`endif
    idle(1, 3);

    // drop_cnt saturation
    cycle(16'h1111, 1, 0, 0, 0);
    cycle(16'h2222, 1, 0, 0, 0);
    cycle(16'h3333, 1, 0, 0, 0);
    cycle(16'h4444, 1, 0, 0, 0);
    for (int k = 0; k < 260; k++) cycle(16'h5678, 0, 1, 0, 0);
    chk("sat_drop", drop_cnt, 255);
    idle(1, 5);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] p;
      bit i, o;
      p = ($urandom_range(3) != 0) ? pool[$urandom_range(7)] : 16'($urandom);
      i = ($urandom_range(2) == 0);
      o = ($urandom_range(2) == 0);
      cycle(p, i, o, $urandom_range(2) == 0, $urandom_range(199) == 0);
    end
    idle(1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
